condiciona_botoes: RTL and testbench

- Input-conditioning stage directly upstream of the neurosync top level.
- Takes the raw active-low pushbuttons from the board (jogar, mais, menos, confirma, botoes[3:0]) and delivers clean active-high levels plus one-cycle pulses. These replace the bare inversions currently feeding the control unit and datapath.
- Functions: 2-flop synchronisation, per-button debounce, press-edge pulse generation, and auto-repeat on mais/menos so a held key steps a value.

---
 rtl/condiciona_botoes_if.sv | 35 +++
 rtl/condiciona_botoes.sv | 156 +++++++++++++++
 tb/tb_condiciona_botoes.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/condiciona_botoes_if.sv
// Raw active-low button lines in, debounced levels and press pulses out.
interface condiciona_botoes_if;
    logic       jogar_n;
    logic       mais_n;
    logic       menos_n;
    logic       confirma_n;
    logic [3:0] botoes_n;

    logic       jogar_nivel;
    logic       mais_nivel;
    logic       menos_nivel;
    logic       confirma_nivel;
    logic [3:0] botoes_nivel;

    logic       jogar_pulso;
    logic       mais_pulso;
    logic       menos_pulso;
    logic       confirma_pulso;
    logic [3:0] botoes_pulso;
    logic       qualquer_pulso;

    modport master (
        output jogar_n, mais_n, menos_n, confirma_n, botoes_n,
        input  jogar_nivel, mais_nivel, menos_nivel, confirma_nivel, botoes_nivel,
        input  jogar_pulso, mais_pulso, menos_pulso, confirma_pulso, botoes_pulso,
        input  qualquer_pulso
    );

    modport slave (
        input  jogar_n, mais_n, menos_n, confirma_n, botoes_n,
        output jogar_nivel, mais_nivel, menos_nivel, confirma_nivel, botoes_nivel,
        output jogar_pulso, mais_pulso, menos_pulso, confirma_pulso, botoes_pulso,
        output qualquer_pulso
    );
endinterface

// File: rtl/condiciona_botoes.sv
// Button conditioning: 2-flop sync, per-input debounce FSM, press pulses,
// and auto-repeat on mais/menos.
module condiciona_botoes #(
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int REPEAT_ATRASO   = 25000000,
    parameter int REPEAT_PERIODO  = 5000000
) (
    input  logic               clock,
    input  logic               reset,
    condiciona_botoes_if.slave bus
);
    // state       | meaning
    // SOLTO       | released
    // PEND_PRESS  | press seen, counting stable samples
    // PRESSIONADO | press accepted
    // PEND_SOLTA  | release seen, counting stable samples
    typedef enum logic [1:0] {SOLTO, PEND_PRESS, PRESSIONADO, PEND_SOLTA} estado_t;

    localparam int N         = 8;
    localparam int IDX_MAIS  = 5;
    localparam int IDX_MENOS = 6;
    localparam int W_CNT     = (DEBOUNCE_CICLOS > 2) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam int REP_MAX   = (REPEAT_ATRASO > REPEAT_PERIODO) ? REPEAT_ATRASO : REPEAT_PERIODO;
    localparam int W_REP     = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;
    localparam logic [W_CNT-1:0] CNT_FIM = W_CNT'(DEBOUNCE_CICLOS - 1);

    // bit order: botoes[3:0], jogar, mais, menos, confirma
    logic [N-1:0] w_raw_n;
    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;
    logic [N-1:0] r_nivel;
    logic [N-1:0] r_pulso;
    logic [N-1:0] w_press;
    logic [N-1:0] w_entra;
    logic [N-1:0] w_nivel_prox;
    logic [1:0]   w_rep_hit;
    logic         w_ambos;

    assign w_raw_n = {bus.confirma_n, bus.menos_n, bus.mais_n, bus.jogar_n, bus.botoes_n};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= w_raw_n;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_deb
        estado_t          r_estado;
        estado_t          w_estado_prox;
        logic [W_CNT-1:0] r_cnt;
        logic [W_CNT-1:0] w_cnt_prox;
        logic             w_p;

        assign w_p = ~r_sync2[i];

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_estado <= SOLTO;
                r_cnt    <= '0;
            end else begin
                r_estado <= w_estado_prox;
                r_cnt    <= w_cnt_prox;
            end
        end

        always_comb begin
            w_estado_prox = r_estado;
            w_cnt_prox    = r_cnt;
            case (r_estado)
                SOLTO: begin
                    if (w_p) begin
                        w_estado_prox = PEND_PRESS;
                        w_cnt_prox    = '0;
                    end
                end
                PEND_PRESS: begin
                    if (!w_p)                  w_estado_prox = SOLTO;
                    else if (r_cnt == CNT_FIM) w_estado_prox = PRESSIONADO;
                    else                       w_cnt_prox    = r_cnt + 1'b1;
                end
                PRESSIONADO: begin
                    if (!w_p) begin
                        w_estado_prox = PEND_SOLTA;
                        w_cnt_prox    = '0;
                    end
                end
                PEND_SOLTA: begin
                    if (w_p)                   w_estado_prox = PRESSIONADO;
                    else if (r_cnt == CNT_FIM) w_estado_prox = SOLTO;
                    else                       w_cnt_prox    = r_cnt + 1'b1;
                end
                default: w_estado_prox = SOLTO;
            endcase
        end

        assign w_press[i]      = (r_estado == PEND_PRESS) && (w_estado_prox == PRESSIONADO);
        assign w_entra[i]      = (r_estado != PRESSIONADO) && (w_estado_prox == PRESSIONADO);
        assign w_nivel_prox[i] = (w_estado_prox == PRESSIONADO) || (w_estado_prox == PEND_SOLTA);
    end

    // Holding both mais and menos parks the repeat timers at the initial delay.
    assign w_ambos = r_nivel[IDX_MAIS] & r_nivel[IDX_MENOS];

    for (genvar j = 0; j < 2; j++) begin : g_rep
        localparam int K = IDX_MAIS + j;
        logic [W_REP-1:0] r_rep;
        logic             r_rep_fase;
        logic [W_REP-1:0] w_rep_fim;

        assign w_rep_fim    = r_rep_fase ? W_REP'(REPEAT_PERIODO - 1) : W_REP'(REPEAT_ATRASO - 1);
        assign w_rep_hit[j] = r_nivel[K] & w_nivel_prox[K] & ~w_entra[K] & ~w_ambos
                              & (r_rep == w_rep_fim);

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_rep      <= '0;
                r_rep_fase <= 1'b0;
            end else if (w_entra[K] || !r_nivel[K] || w_ambos) begin
                r_rep      <= '0;
                r_rep_fase <= 1'b0;
            end else if (r_rep == w_rep_fim) begin
                r_rep      <= '0;
                r_rep_fase <= 1'b1;
            end else begin
                r_rep <= r_rep + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_nivel <= '0;
            r_pulso <= '0;
        end else begin
            r_nivel <= w_nivel_prox;
            r_pulso <= w_press | {1'b0, w_rep_hit, 5'b0};
        end
    end

    assign bus.botoes_nivel   = r_nivel[3:0];
    assign bus.jogar_nivel    = r_nivel[4];
    assign bus.mais_nivel     = r_nivel[IDX_MAIS];
    assign bus.menos_nivel    = r_nivel[IDX_MENOS];
    assign bus.confirma_nivel = r_nivel[7];

    assign bus.botoes_pulso   = r_pulso[3:0];
    assign bus.jogar_pulso    = r_pulso[4];
    assign bus.mais_pulso     = r_pulso[IDX_MAIS];
    assign bus.menos_pulso    = r_pulso[IDX_MENOS];
    assign bus.confirma_pulso = r_pulso[7];
    assign bus.qualquer_pulso = |r_pulso[3:0];
endmodule

// File: tb/tb_condiciona_botoes.sv
// Directed bench for condiciona_botoes with an event scoreboard checked every cycle.
module tb_condiciona_botoes;
    logic       clock;
    logic       reset;
    logic [7:0] raw;          // {confirma, menos, mais, jogar, botoes[3:0]}, 0 = pressed
    int         cyc;
    int         n_assert;
    int         n_fail;
    logic [7:0] exp_nivel;

    typedef struct {
        int         e;        // edge at which the event becomes visible
        logic       k;        // 0 = pulse, 1 = level change
        logic [7:0] m;
        logic       v;
    } ev_t;
    ev_t q[$];

    condiciona_botoes_if bus ();

    assign bus.botoes_n   = raw[3:0];
    assign bus.jogar_n    = raw[4];
    assign bus.mais_n     = raw[5];
    assign bus.menos_n    = raw[6];
    assign bus.confirma_n = raw[7];

    logic [7:0] obs_nivel;
    logic [7:0] obs_pulso;
    assign obs_nivel = {bus.confirma_nivel, bus.menos_nivel, bus.mais_nivel, bus.jogar_nivel, bus.botoes_nivel};
    assign obs_pulso = {bus.confirma_pulso, bus.menos_pulso, bus.mais_pulso, bus.jogar_pulso, bus.botoes_pulso};

    condiciona_botoes #(
        .DEBOUNCE_CICLOS(4),
        .REPEAT_ATRASO  (8),
        .REPEAT_PERIODO (4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, expv);
        end
    endtask

    task automatic push(input int e, input logic k, input logic [7:0] m, input logic v);
        ev_t ev;
        int  pos;
        ev.e = e;
        ev.k = k;
        ev.m = m;
        ev.v = v;
        pos = q.size();
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].e > e) pos = i;
        end
        q.insert(pos, ev);
    endtask

    task automatic step();
        logic [7:0] exp_p;
        ev_t        ev;
        @(posedge clock);
        cyc++;
        #1;
        exp_p = '0;
        while (q.size() > 0 && q[0].e <= cyc) begin
            ev = q.pop_front();
            if (ev.k) exp_nivel = ev.v ? (exp_nivel | ev.m) : (exp_nivel & ~ev.m);
            else      exp_p     = exp_p | ev.m;
        end
        chk("pulso", obs_pulso, exp_p);
        chk("nivel", obs_nivel, exp_nivel);
        chk("qualquer", {7'b0, bus.qualquer_pulso}, {7'b0, |exp_p[3:0]});
    endtask

    // Raw change now is seen at edge cyc+1; outputs follow six edges later.
    task automatic press(input logic [7:0] m);
        raw = raw & ~m;
        push(cyc + 7, 1'b0, m, 1'b0);
        push(cyc + 7, 1'b1, m, 1'b1);
    endtask

    task automatic release_btn(input logic [7:0] m);
        raw = raw | m;
        push(cyc + 7, 1'b1, m, 1'b0);
    endtask

    initial begin
        int c0;
        n_assert  = 0;
        n_fail    = 0;
        cyc       = 0;
        exp_nivel = '0;
        raw       = '0;
        reset     = 1'b0;

        // reset held with every button pressed
        repeat (3) step();
        reset = 1'b1;
        push(cyc + 7, 1'b0, 8'hFF, 1'b0);
        push(cyc + 7, 1'b1, 8'hFF, 1'b1);
        repeat (10) step();
        release_btn(8'hFF);
        repeat (12) step();

        // clean press on botoes[2]
        press(8'h04);
        repeat (20) step();
        release_btn(8'h04);
        repeat (10) step();

        // confirma bouncing every 2 cycles, then steady
        for (int i = 0; i < 10; i++) begin
            raw[7] = (i % 2 == 1);
            repeat (2) step();
        end
        press(8'h80);
        repeat (12) step();
        release_btn(8'h80);
        repeat (10) step();

        // mais held: press pulse, then repeats after 8 and every 4
        c0 = cyc;
        press(8'h20);
        for (int e = c0 + 15; e < c0 + 47; e += 4) push(e, 1'b0, 8'h20, 1'b0);
        repeat (40) step();
        release_btn(8'h20);
        repeat (12) step();

        // mais+menos together: no repeat until menos released
        c0 = cyc;
        press(8'h60);
        repeat (20) step();
        release_btn(8'h40);
        for (int e = c0 + 35; e < c0 + 51; e += 4) push(e, 1'b0, 8'h20, 1'b0);
        repeat (24) step();
        release_btn(8'h20);
        repeat (12) step();

        // async reset while jogar debounces and botoes[1] is accepted
        press(8'h02);
        repeat (12) step();
        raw[4] = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        q.delete();
        exp_nivel = '0;
        #1;
        chk("async_nivel", obs_nivel, 8'h00);
        chk("async_pulso", obs_pulso, 8'h00);
        repeat (2) step();
        reset = 1'b1;
        push(cyc + 7, 1'b0, 8'h12, 1'b0);
        push(cyc + 7, 1'b1, 8'h12, 1'b1);
        repeat (12) step();
        release_btn(8'h12);
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
